// File: rtl/ct_spsram_128x16_ctrl_if.sv
// Request-side and SRAM-side signals of the 128x16 single-port SRAM controller.
// slave  : the controller itself
// master : requesters plus the SRAM macro (the environment around the controller)
interface ct_spsram_128x16_ctrl_if;
    logic        inv_req;
    logic        wr_vld;
    logic [6:0]  wr_idx;
    logic [15:0] wr_data;
    logic [15:0] wr_bmask;
    logic        wr_grant;
    logic        rd_vld;
    logic [6:0]  rd_idx;
    logic        rd_grant;
    logic        rd_data_vld;
    logic [15:0] rd_data;
    logic        init_done;
    logic [6:0]  sram_a;
    logic        sram_cen;
    logic        sram_gwen;
    logic [15:0] sram_wen;
    logic [15:0] sram_d;
    logic [15:0] sram_q;

    modport slave (
        input  inv_req, wr_vld, wr_idx, wr_data, wr_bmask, rd_vld, rd_idx, sram_q,
        output wr_grant, rd_grant, rd_data_vld, rd_data, init_done,
               sram_a, sram_cen, sram_gwen, sram_wen, sram_d
    );

    modport master (
        output inv_req, wr_vld, wr_idx, wr_data, wr_bmask, rd_vld, rd_idx, sram_q,
        input  wr_grant, rd_grant, rd_data_vld, rd_data, init_done,
               sram_a, sram_cen, sram_gwen, sram_wen, sram_d
    );
endinterface

// File: rtl/ct_spsram_128x16_ctrl.sv
// Controller for a 128x16 single-port SRAM: zero-fill sweep after reset or
// invalidate, then write/read arbitration with read anti-starvation.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// ST_INIT  | sweeping idx 0..127 writing zero, no grants, inv_req ignored
// ST_READY | array valid, init_done=1, requests arbitrated
module ct_spsram_128x16_ctrl (
    input  logic                          forever_cpuclk,
    input  logic                          cpurst,
    ct_spsram_128x16_ctrl_if.slave        bus
);
    typedef enum logic {
        ST_INIT  = 1'b0,
        ST_READY = 1'b1
    } state_t;

    state_t      state_q;
    logic [6:0]  cnt_q;
    logic [1:0]  starv_q;
    logic        rd_data_vld_q;

    // Last driven SRAM address/data/bit-enables, held while the macro is idle
    logic [6:0]  sram_a_q, sram_a_d;
    logic [15:0] sram_d_q, sram_d_d;
    logic [15:0] sram_wen_q, sram_wen_d;
    logic        sram_cen_d, sram_gwen_d;

    logic        in_init, in_ready, rd_win, wr_grant, rd_grant;

    // Arbitration: write wins unless the read has waited three cycles
    always_comb begin
        in_init  = (state_q == ST_INIT) && !cpurst;
        in_ready = (state_q == ST_READY) && !cpurst;
        rd_win   = bus.rd_vld && ((starv_q == 2'd3) || !bus.wr_vld);
        rd_grant = in_ready && rd_win;
        wr_grant = in_ready && bus.wr_vld && !rd_win;
    end

    // SRAM port drive; idle cycles replay the held address/data/enables
    always_comb begin
        sram_cen_d  = 1'b1;
        sram_gwen_d = 1'b1;
        sram_a_d    = sram_a_q;
        sram_d_d    = sram_d_q;
        sram_wen_d  = sram_wen_q;
        if (in_init) begin
            sram_cen_d  = 1'b0;
            sram_gwen_d = 1'b0;
            sram_a_d    = cnt_q;
            sram_d_d    = 16'h0000;
            sram_wen_d  = 16'h0000;
        end else if (wr_grant) begin
            sram_cen_d  = 1'b0;
            sram_gwen_d = 1'b0;
            sram_a_d    = bus.wr_idx;
            sram_d_d    = bus.wr_data;
            sram_wen_d  = ~bus.wr_bmask;
        end else if (rd_grant) begin
            sram_cen_d  = 1'b0;
            sram_gwen_d = 1'b1;
            sram_a_d    = bus.rd_idx;
            sram_wen_d  = 16'hFFFF;
        end
    end

    // Capture whatever was driven so an idle cycle keeps the bus quiet
    always_ff @(posedge forever_cpuclk) begin
        sram_a_q   <= sram_a_d;
        sram_d_q   <= sram_d_d;
        sram_wen_q <= sram_wen_d;
    end

    // FSM, sweep counter, starvation counter and read-return flag
    always_ff @(posedge forever_cpuclk) begin
        if (cpurst) begin
            state_q       <= ST_INIT;
            cnt_q         <= 7'd0;
            starv_q       <= 2'd0;
            rd_data_vld_q <= 1'b0;
        end else begin
            rd_data_vld_q <= rd_grant;
            if (bus.rd_vld && !rd_grant) begin
                if (starv_q != 2'd3) begin
                    starv_q <= starv_q + 2'd1;
                end
            end else begin
                starv_q <= 2'd0;
            end
            case (state_q)
                ST_INIT: begin
                    cnt_q <= cnt_q + 7'd1;
                    if (cnt_q == 7'd127) begin
                        state_q <= ST_READY;
                    end
                end
                ST_READY: begin
                    if (bus.inv_req) begin
                        state_q <= ST_INIT;
                        cnt_q   <= 7'd0;
                    end
                end
                default: begin
                    state_q <= ST_INIT;
                    cnt_q   <= 7'd0;
                end
            endcase
        end
    end

    assign bus.wr_grant    = wr_grant;
    assign bus.rd_grant    = rd_grant;
    assign bus.rd_data_vld = rd_data_vld_q;
    assign bus.rd_data     = bus.sram_q;
    assign bus.init_done   = in_ready;
    assign bus.sram_a      = sram_a_d;
    assign bus.sram_cen    = sram_cen_d;
    assign bus.sram_gwen   = sram_gwen_d;
    assign bus.sram_wen    = sram_wen_d;
    assign bus.sram_d      = sram_d_d;
endmodule

// File: tb/tb_ct_spsram_128x16_ctrl.sv
// Directed bench for ct_spsram_128x16_ctrl with a behavioural 128x16 SRAM.
module tb_ct_spsram_128x16_ctrl;
    logic clk;
    logic cpurst;
    int   n_chk;
    int   n_err;

    ct_spsram_128x16_ctrl_if bus ();

    ct_spsram_128x16_ctrl dut (
        .forever_cpuclk (clk),
        .cpurst         (cpurst),
        .bus            (bus)
    );

    // Behavioural SRAM: active-low bit write enables, one-cycle read latency
    logic [15:0] mem [128];
    logic [15:0] q_r;
    assign bus.sram_q = q_r;

    always @(posedge clk) begin
        if (!bus.sram_cen) begin
            if (!bus.sram_gwen) begin
                mem[bus.sram_a] <= (mem[bus.sram_a] & bus.sram_wen) | (bus.sram_d & ~bus.sram_wen);
            end else begin
                q_r <= mem[bus.sram_a];
            end
        end
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required earlier finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [47:0] got, input logic [47:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Follows an in-progress sweep one cycle at a time, starting at idx 0
    task automatic run_sweep(input int stop_at, output int k, output int bad);
        k   = 0;
        bad = 0;
        while (!bus.init_done && k < stop_at) begin
            if (bus.sram_cen !== 1'b0 || bus.sram_gwen !== 1'b0 || bus.sram_a !== k[6:0] ||
                bus.sram_wen !== 16'h0000 || bus.sram_d !== 16'h0000 ||
                bus.wr_grant !== 1'b0 || bus.rd_grant !== 1'b0) begin
                bad++;
            end
            bus.inv_req = (k == 40);
            @(negedge clk);
            #1;
            k++;
        end
        bus.inv_req = 1'b0;
    endtask

    // Called at a negedge; returns at the negedge after the granted cycle
    task automatic do_write(input logic [6:0] idx, input logic [15:0] data, input logic [15:0] mask);
        int n;
        n = 0;
        bus.wr_vld   = 1'b1;
        bus.wr_idx   = idx;
        bus.wr_data  = data;
        bus.wr_bmask = mask;
        #1;
        while (!bus.wr_grant && n < 20) begin
            @(negedge clk);
            #1;
            n++;
        end
        check("wr_grant", {47'd0, bus.wr_grant}, 48'd1);
        check("wr_bus", {7'd0, bus.sram_cen, bus.sram_gwen, bus.sram_a, bus.sram_wen, bus.sram_d},
              {7'd0, 1'b0, 1'b0, idx, ~mask, data});
        @(negedge clk);
        bus.wr_vld = 1'b0;
    endtask

    // Called at a negedge; returns one step past the negedge of the data cycle
    task automatic do_read(input logic [6:0] idx, input logic [15:0] exp);
        int n;
        n = 0;
        bus.rd_vld = 1'b1;
        bus.rd_idx = idx;
        #1;
        while (!bus.rd_grant && n < 20) begin
            @(negedge clk);
            #1;
            n++;
        end
        check("rd_grant", {47'd0, bus.rd_grant}, 48'd1);
        check("rd_bus", {23'd0, bus.sram_cen, bus.sram_gwen, bus.sram_a, bus.sram_wen},
              {23'd0, 1'b0, 1'b1, idx, 16'hFFFF});
        @(negedge clk);
        bus.rd_vld = 1'b0;
        #1;
        check("rd_data_vld", {47'd0, bus.rd_data_vld}, 48'd1);
        check("rd_data", {32'd0, bus.rd_data}, {32'd0, exp});
    endtask

    function automatic int count_nonzero();
        int c;
        c = 0;
        for (int i = 0; i < 128; i++) begin
            if (mem[i] !== 16'h0000) c++;
        end
        return c;
    endfunction

    initial begin
        int k;
        int bad;
        logic [1:0] exp_g;

        n_chk = 0;
        n_err = 0;
        for (int i = 0; i < 128; i++) mem[i] = 16'h8000 | 16'($urandom_range(1, 16'h7FFF));
        q_r          = 16'h0000;
        cpurst       = 1'b1;
        bus.inv_req  = 1'b0;
        bus.wr_vld   = 1'b1;
        bus.wr_idx   = 7'd3;
        bus.wr_data  = 16'h1111;
        bus.wr_bmask = 16'hFFFF;
        bus.rd_vld   = 1'b1;
        bus.rd_idx   = 7'd3;

        repeat (3) @(negedge clk);
        #1;
        check("rst_outputs", {40'd0, bus.sram_cen, bus.sram_gwen, bus.wr_grant, bus.rd_grant, bus.init_done, 3'd0},
              {40'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0});

        // Release reset; requests stay up through the sweep and must not be granted
        @(negedge clk);
        cpurst = 1'b0;
        #1;
        check("post_rst", {39'd0, bus.rd_data_vld, bus.init_done, bus.sram_a},
              {39'd0, 1'b0, 1'b0, 7'd0});
        run_sweep(300, k, bad);
        bus.wr_vld = 1'b0;
        bus.rd_vld = 1'b0;
        check("init_cycles", 48'(k), 48'd128);
        check("init_pattern", 48'(bad), 48'd0);
        check("init_zero", 48'(count_nonzero()), 48'd0);

        // Full-mask write, idle hold, read back
        @(negedge clk);
        do_write(7'd5, 16'hA5A5, 16'hFFFF);
        #1;
        check("idle_hold", {7'd0, bus.sram_cen, bus.sram_gwen, bus.sram_a, bus.sram_wen, bus.sram_d},
              {7'd0, 1'b1, 1'b1, 7'd5, 16'h0000, 16'hA5A5});
        @(negedge clk);
        do_read(7'd5, 16'hA5A5);

        // Partial-mask write immediately followed by read of the same idx
        @(negedge clk);
        do_write(7'd5, 16'h0F0F, 16'h00FF);
        do_read(7'd5, 16'hA50F);

        // Zero mask consumes a grant but leaves data alone
        @(negedge clk);
        do_write(7'd5, 16'hFFFF, 16'h0000);
        do_read(7'd5, 16'hA50F);

        // Both requesters held: three writes then one read, repeating
        @(negedge clk);
        bus.wr_vld   = 1'b1;
        bus.wr_idx   = 7'd9;
        bus.wr_data  = 16'h1234;
        bus.wr_bmask = 16'hFFFF;
        bus.rd_vld   = 1'b1;
        bus.rd_idx   = 7'd5;
        for (int i = 0; i < 12; i++) begin
            #1;
            exp_g = ((i % 4) == 3) ? 2'b01 : 2'b10;
            check("arb", {46'd0, bus.wr_grant, bus.rd_grant}, {46'd0, exp_g});
            @(negedge clk);
        end
        bus.wr_vld = 1'b0;
        bus.rd_vld = 1'b0;

        // Invalidate while a read is granted in the same cycle
        @(negedge clk);
        do_write(7'd20, 16'hBEEF, 16'hFFFF);
        bus.inv_req = 1'b1;
        bus.rd_vld  = 1'b1;
        bus.rd_idx  = 7'd20;
        #1;
        check("inv_rd_grant", {46'd0, bus.rd_grant, bus.init_done}, {46'd0, 1'b1, 1'b1});
        @(negedge clk);
        bus.inv_req  = 1'b0;
        bus.wr_vld   = 1'b1;
        bus.wr_data  = 16'hFFFF;
        bus.wr_bmask = 16'hFFFF;
        #1;
        check("inv_next", {30'd0, bus.init_done, bus.rd_data_vld, bus.rd_data},
              {30'd0, 1'b0, 1'b1, 16'hBEEF});
        run_sweep(300, k, bad);
        bus.wr_vld = 1'b0;
        bus.rd_vld = 1'b0;
        check("inv_cycles", 48'(k), 48'd128);
        check("inv_pattern", 48'(bad), 48'd0);
        @(negedge clk);
        do_read(7'd20, 16'h0000);
        @(negedge clk);
        do_read(7'd127, 16'h0000);

        // Reset in the middle of a granted read drops the pending return
        @(negedge clk);
        do_write(7'd33, 16'h5A5A, 16'hFFFF);
        bus.rd_vld = 1'b1;
        bus.rd_idx = 7'd33;
        #1;
        check("rst_rd_grant", {47'd0, bus.rd_grant}, 48'd1);
        cpurst = 1'b1;
        @(negedge clk);
        bus.rd_vld = 1'b0;
        #1;
        check("rst_rd_drop", {45'd0, bus.rd_data_vld, bus.sram_cen, bus.init_done},
              {45'd0, 1'b0, 1'b1, 1'b0});
        @(negedge clk);
        cpurst = 1'b0;
        #1;

        // Reset at sweep idx 60 restarts the sweep from idx 0
        run_sweep(60, k, bad);
        check("mid_sweep_pos", {41'd0, bus.sram_a}, {41'd0, 7'd60});
        check("mid_sweep_pattern", 48'(bad), 48'd0);
        cpurst = 1'b1;
        @(negedge clk);
        #1;
        check("mid_sweep_rst", {46'd0, bus.sram_cen, bus.init_done}, {46'd0, 1'b1, 1'b0});
        @(negedge clk);
        cpurst = 1'b0;
        #1;
        check("restart_idx", {40'd0, bus.sram_cen, bus.sram_a}, {40'd0, 1'b0, 7'd0});
        run_sweep(300, k, bad);
        check("restart_cycles", 48'(k), 48'd128);
        check("restart_pattern", 48'(bad), 48'd0);
        check("restart_zero", 48'(count_nonzero()), 48'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule

// File: doc/ct_spsram_128x16_ctrl.md
CT_SPSRAM_128X16_CTRL -- requirements
Module: ct_spsram_128x16_ctrl

Interface
REQ-001 SHALL have port forever_cpuclk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-002 SHALL have port cpurst, input, 1 bit: reset, synchronous, active-high.
REQ-003 SHALL have port inv_req, input, 1 bit: single-cycle pulse requesting a full clear of the array.
REQ-004 SHALL have ports wr_vld (input, 1), wr_idx (input, 7), wr_data (input, 16) and wr_bmask (input, 16): write request, address, data and per-bit write enable (1 = write that bit).
REQ-005 SHALL have ports wr_grant (output, 1): write accepted this cycle.
REQ-006 SHALL have ports rd_vld (input, 1) and rd_idx (input, 7): read request and address.
REQ-007 SHALL have port rd_grant (output, 1): read accepted this cycle.
REQ-008 SHALL have ports rd_data_vld (output, 1) and rd_data (output, 16): read return, equal to sram_q.
REQ-009 SHALL have port init_done (output, 1): array cleared and ready for requests.
REQ-010 SHALL have ports sram_a (output, 7), sram_cen (output, 1, active-low), sram_gwen (output, 1, active-low write), sram_wen (output, 16, active-low bit enable), sram_d (output, 16) and sram_q (input, 16), which connect to the 128x16 single-port SRAM.

Function
REQ-011 SHALL implement two states, INIT and READY, and SHALL enter INIT on reset.
REQ-012 In INIT, SHALL write zero to one entry per cycle, idx 0..127, driving sram_cen=0, sram_gwen=0, sram_wen=16'h0000, sram_d=0 and sram_a=the sweep counter.
REQ-013 SHALL move from INIT to READY in the cycle after the counter=127 write; init_done SHALL be 1 exactly when in READY; the sweep SHALL take 128 cycles.
REQ-014 In INIT, wr_grant and rd_grant SHALL be 0 and inv_req SHALL be ignored.
REQ-015 In READY, an inv_req pulse SHALL move the block to INIT with counter 0 in the next cycle; any request granted in the inv_req cycle SHALL still complete.
REQ-016 In READY, grants SHALL be combinational from the request inputs and the current state; a requester SHALL hold vld and its fields stable until granted.
REQ-017 Default priority SHALL be write over read.
REQ-018 SHALL keep a 2-bit starvation counter that increments when rd_vld=1 and rd_grant=0, saturating at 3; it SHALL clear on rd_grant, when rd_vld=0, and on reset.
REQ-019 When the starvation counter=3 and rd_vld=1, read SHALL win over a concurrent write.
REQ-020 At most one grant SHALL be asserted per cycle.
REQ-021 When a write is granted, the block SHALL drive sram_cen=0, sram_gwen=0, sram_a=wr_idx, sram_d=wr_data and sram_wen=~wr_bmask.
REQ-022 When a read is granted, the block SHALL drive sram_cen=0, sram_gwen=1, sram_a=rd_idx and sram_wen=16'hFFFF.
REQ-023 When no access is made, the block SHALL drive sram_cen=1 and sram_gwen=1, and sram_a, sram_d and sram_wen SHALL hold their last values.
REQ-024 rd_data_vld SHALL be a register set to 1 in the cycle after rd_grant; read latency SHALL be 1 cycle.
REQ-025 rd_data SHALL equal sram_q without further registering.
REQ-026 A write followed in the next cycle by a read of the same idx SHALL return the new data.
REQ-027 A wr_bmask of 0 SHALL still consume a grant and SHALL leave the data in the array unchanged.

Reset
REQ-028 While cpurst=1, the block SHALL drive sram_cen=1, sram_gwen=1, wr_grant=0, rd_grant=0 and init_done=0.
REQ-029 In the cycle after cpurst falls, rd_data_vld SHALL be 0, the state SHALL be INIT, the sweep counter SHALL be 0 and the starvation counter SHALL be 0.
REQ-030 Reset asserted in the middle of the INIT sweep or in the middle of a read SHALL abandon the operation, suppress the pending rd_data_vld and restart the sweep at idx 0.

Verification
REQ-031 The bench SHALL release reset and count cycles to init_done: init_done=1 exactly 128 cycles later, and every idx 0..127 SHALL have been written with 0.
REQ-032 The bench SHALL write idx 5 with data 16'hA5A5 and wr_bmask 16'hFFFF, then read idx 5: rd_data_vld=1 one cycle after rd_grant, with rd_data=16'hA5A5.
REQ-033 The bench SHALL write idx 5 with data 16'h0F0F and wr_bmask 16'h00FF over existing data 16'hA5A5, then read idx 5: rd_data=16'hA50F.
REQ-034 The bench SHALL hold wr_vld and rd_vld high continuously: writes SHALL be granted 3 cycles, then a read 1 cycle, repeating; grants SHALL never overlap.
REQ-035 The bench SHALL pulse inv_req in READY: init_done SHALL fall the next cycle, grants SHALL be 0 for 128 cycles, and a later read of any idx SHALL return 0.
REQ-036 The bench SHALL assert cpurst at sweep idx 60: the sweep SHALL restart at idx 0, and init_done SHALL rise 128 cycles after reset release.
